// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// multiply-accumulate into HI/LO, cancellable by IntReq.
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IntReq,
    input  logic             start,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HIWrite,
    input  logic             LOWrite,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2:0]         op_q;
    logic               sa_q;
    logic               sb_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               is_div;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   remd;
    logic [2*WIDTH-1:0] fix_res;

    always_comb begin
        abs_a     = (MDUOp[0] && A[WIDTH-1]) ? -A : A;
        abs_b     = (MDUOp[0] && B[WIDTH-1]) ? -B : B;
        is_div    = (op_q[2:1] == 2'b01);

        // Multiply: {rem_q, quo_q} is the partial product shifting right.
        mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        // Divide: rem_q is the partial remainder, quo_q shifts dividend out / quotient in.
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift[WIDTH-1:0] - b_q;

        prod = {rem_q, quo_q};
        if (op_q[0] && (sa_q ^ sb_q)) begin
            prod = -prod;
        end
        quot = quo_q;
        remd = rem_q;
        if (op_q[0] && (sa_q ^ sb_q)) begin
            quot = -quot;
        end
        if (op_q[0] && sa_q) begin
            remd = -remd;
        end
        // Remainder already equals A on divide by zero; only the quotient needs forcing.
        if (b_q == '0) begin
            quot = '1;
        end

        if (is_div) begin
            fix_res = {remd, quot};
        end else if (op_q[2]) begin
            fix_res = op_q[1] ? (acc_q - prod) : (acc_q + prod);
        end else begin
            fix_res = prod;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (IntReq) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q <= StCalc;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            op_q    <= MDUOp;
                            sa_q    <= MDUOp[0] & A[WIDTH-1];
                            sb_q    <= MDUOp[0] & B[WIDTH-1];
                            rem_q   <= '0;
                            quo_q   <= abs_a;
                            b_q     <= abs_b;
                            acc_q   <= {hi_q, lo_q};
                        end else begin
                            if (HIWrite) begin
                                hi_q <= A;
                            end
                            if (LOWrite) begin
                                lo_q <= A;
                            end
                        end
                    end
                    StCalc: begin
                        if (is_div) begin
                            rem_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                            quo_q <= {quo_q[WIDTH-2:0], div_ge};
                        end else begin
                            rem_q <= mul_sum[WIDTH:1];
                            quo_q <= {mul_sum[0], quo_q[WIDTH-1:1]};
                        end
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == CntW'(WIDTH - 1)) begin
                            state_q <= StFix;
                        end
                    end
                    StFix: begin
                        {hi_q, lo_q} <= fix_res;
                        state_q      <= StIdle;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomised and directed bench for mdu_iter against an arithmetic reference model.
module tb_mdu_iter;
    localparam int unsigned WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        int_req;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_iter #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .IntReq (int_req),
        .start  (start),
        .MDUOp  (mdu_op),
        .A      (a_in),
        .B      (b_in),
        .HIWrite(hi_write),
        .LOWrite(lo_write),
        .HI     (hi_out),
        .LO     (lo_out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the operand values.
    function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] hilo);
        longint      sa;
        longint      sb;
        longint      qq;
        longint      rr;
        logic [63:0] p;
        sa = op[0] ? longint'($signed(a)) : longint'(a);
        sb = op[0] ? longint'($signed(b)) : longint'(b);
        if (op[2:1] == 2'b01) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            qq = sa / sb;
            rr = sa % sb;
            return {rr[31:0], qq[31:0]};
        end
        p = sa * sb;
        if (!op[2]) return p;
        return op[1] ? hilo - p : hilo + p;
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] edges [5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF};
        case ($urandom_range(0, 4))
            0:       return $urandom_range(0, 9);
            1:       return -$urandom_range(1, 9);
            2:       return edges[$urandom_range(0, 4)];
            default: return $urandom;
        endcase
    endfunction

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit wr);
        @(negedge clk);
        start = 1'b1; mdu_op = op; a_in = a; b_in = b; hi_write = wr; lo_write = wr;
        @(negedge clk);
        start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic finish_op(input string tag);
        check_eq({tag, ".done"}, done, 1);
        check_eq({tag, ".hilo"}, {hi_out, lo_out}, {m_hi, m_lo});
        @(negedge clk);
        check_eq({tag, ".done_once"}, done, 0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit wr);
        int cyc;
        {m_hi, m_lo} = ref_mdu(op, a, b, {m_hi, m_lo});
        launch(op, a, b, wr);
        wait_idle(cyc);
        check_eq({tag, ".busy_cycles"}, cyc, WIDTH + 1);
        finish_op(tag);
    endtask

    task automatic mt(input bit hw, input bit lw, input logic [31:0] v);
        @(negedge clk);
        hi_write = hw; lo_write = lw; a_in = v;
        @(negedge clk);
        hi_write = 1'b0; lo_write = 1'b0;
        if (hw) m_hi = v;
        if (lw) m_lo = v;
        check_eq("mt.hilo", {hi_out, lo_out}, {m_hi, m_lo});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        reset = 1'b1; int_req = 1'b0; start = 1'b0; mdu_op = '0;
        a_in = '0; b_in = '0; hi_write = 1'b0; lo_write = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        check_eq("reset.hilo", {hi_out, lo_out}, 64'd0);
        check_eq("reset.busy", busy, 0);
        check_eq("reset.done", done, 0);
        reset = 1'b0;

        // Directed cases from the arithmetic rules
        run_op("mult_neg", 3'b001, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check_eq("mult_neg.const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu_max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_eq("multu_max.const", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
        run_op("div_neg", 3'b011, -32'd7, 32'd2, 1'b0);
        check_eq("div_neg.const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_zero", 3'b010, 32'd7, 32'd0, 1'b0);
        check_eq("divu_zero.const", {hi_out, lo_out}, 64'h0000_0007_FFFF_FFFF);
        run_op("div_zero_neg", 3'b011, -32'd5, 32'd0, 1'b0);
        run_op("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_eq("div_ovf.const", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
        mt(1'b1, 1'b0, 32'd0);
        mt(1'b0, 1'b1, 32'd10);
        run_op("maddu", 3'b100, 32'd3, 32'd4, 1'b0);
        check_eq("maddu.const", {hi_out, lo_out}, 64'd22);
        run_op("msub", 3'b111, 32'd5, 32'd5, 1'b0);
        check_eq("msub.const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);

        // Randomised operations interleaved with mthi/mtlo
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) mt(1'($urandom_range(0, 1)), 1'b1, rnd_val());
            run_op("rand", 3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 1'b0);
        end

        // Simultaneous mthi/mtlo both apply
        mt(1'b1, 1'b1, 32'h1357_9BDF);

        // start with HIWrite/LOWrite: the writes are dropped
        run_op("start_wr", 3'b000, 32'd9, 32'd9, 1'b1);

        // IntReq with start in IDLE: start ignored
        @(negedge clk);
        start = 1'b1; int_req = 1'b1; mdu_op = 3'b000; a_in = 32'd2; b_in = 32'd2;
        @(negedge clk);
        start = 1'b0; int_req = 1'b0;
        check_eq("int_idle.busy", busy, 0);
        @(negedge clk);
        check_eq("int_idle.done", done, 0);
        check_eq("int_idle.hilo", {hi_out, lo_out}, {m_hi, m_lo});

        // IntReq on CALC cycle 10 cancels a divide
        mt(1'b1, 1'b1, 32'h0000_CAFE);
        launch(3'b010, 32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        int_req = 1'b1;
        @(negedge clk);
        int_req = 1'b0;
        check_eq("int_calc.busy", busy, 0);
        check_eq("int_calc.done", done, 0);
        check_eq("int_calc.hilo", {hi_out, lo_out}, {m_hi, m_lo});
        @(negedge clk);
        check_eq("int_calc.no_done", done, 0);
        run_op("int_restart", 3'b010, 32'd100, 32'd7, 1'b0);

        // start / mthi / mtlo while busy are ignored
        {m_hi, m_lo} = ref_mdu(3'b000, 32'h0001_0001, 32'h0002_0003, {m_hi, m_lo});
        launch(3'b000, 32'h0001_0001, 32'h0002_0003, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; mdu_op = 3'b010; a_in = 32'h5555; b_in = 32'd1;
        hi_write = 1'b1; lo_write = 1'b1;
        @(negedge clk);
        start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
        wait_idle(cyc);
        check_eq("busy_ign.cycles", cyc, WIDTH + 1 - 5);
        finish_op("busy_ign");
        check_eq("busy_ign.idle", busy, 0);

        // Asynchronous reset between edges mid-CALC
        mt(1'b1, 1'b1, 32'h1234_5678);
        launch(3'b001, 32'hDEAD_BEEF, 32'h0000_1111, 1'b0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("areset.busy", busy, 0);
        check_eq("areset.hilo", {hi_out, lo_out}, 64'd0);
        check_eq("areset.done", done, 0);
        #1 reset = 1'b0;
        m_hi = '0; m_lo = '0;
        run_op("after_reset", 3'b101, 32'hFFFF_FFFD, 32'd7, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
